// File: rtl/nrisc_control.sv
// ---------------------------------------------------------------------------
// nrisc_control
//
// Multi-cycle fetch/decode/execute/writeback controller that sits directly
// upstream of the nRisc ALU. Each instruction is fetched over a req/valid
// memory port. It is decoded against a 4 x 2-bit register file. The decode
// result is presented to the ALU as ALUctl/A/B. The sampled ALU result is
// then written back.
//
// Instruction byte: [7:4] op, [3:2] rs, [1:0] rt, branch offset [3:0] signed.
//   0 SLT, 2 MOV, 4 INC, 5 SUB, 7 ADD : reg[rs] <= ALUOut[1:0], zflag <= Zero
//   8 BEQZ : PC <= zflag ? PC+sext(off) : PC+1
//   9 JMP  : PC <= PC+sext(off)
//   15 HALT: enter the terminal HALT state
//   others : NOP (PC+1)
//
// Parameters
//   PC_W      program counter width (>= 4), PC wraps modulo 2**PC_W
//   RESET_PC  PC value loaded on reset
//
// Ports
//   clk, rst_n               clock, asynchronous active-low reset
//   imem_req/imem_addr       fetch request and address (= PC), FETCH only
//   imem_rdata/imem_valid    fetch data, sampled in FETCH when valid
//   ALUctl, A, B             ALU operation and operands (registered)
//   ALUOut, Zero             ALU result and zero flag
//   halted                   sticky, set by HALT
//   reg_dump                 {reg3, reg2, reg1, reg0}
//   retired                  retired-instruction counter, present only
//                            when NRISC_RETIRE_CNT_EN is defined
// ---------------------------------------------------------------------------
module nrisc_control #(
    parameter int              PC_W     = 8,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic [7:0]      imem_rdata,
    input  logic            imem_valid,
    output logic [3:0]      ALUctl,
    output logic [1:0]      A,
    output logic [1:0]      B,
    input  logic [8:0]      ALUOut,
    input  logic            Zero,
    output logic            halted,
    output logic [7:0]      reg_dump
`ifdef NRISC_RETIRE_CNT_EN
    ,
    output logic [15:0]     retired
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_WB,
        S_HALT
    } state_t;

    state_t              state_reg;
    logic [PC_W-1:0]     pc_reg;
    logic [7:0]          ir_reg;
    logic [3:0][1:0]     rf_reg;
    logic                zflag_reg;
    logic [1:0]          res_reg;     // ALUOut[1:0] sampled at the end of EXEC
    logic                zero_reg;    // full 9-bit Zero sampled with it
`ifdef NRISC_RETIRE_CNT_EN
    logic [15:0]         retired_reg;
`endif

    logic [3:0]          op;
    logic [1:0]          rs;
    logic [1:0]          rt;
    logic                is_alu;
    logic [PC_W-1:0]     off_ext;
    logic [PC_W-1:0]     pc_plus1;
    logic [PC_W-1:0]     pc_branch;

    assign op        = ir_reg[7:4];
    assign rs        = ir_reg[3:2];
    assign rt        = ir_reg[1:0];
    assign is_alu    = (op == 4'd0) || (op == 4'd2) || (op == 4'd4) ||
                       (op == 4'd5) || (op == 4'd7);
    // Signed cast first so the size cast sign-extends the 4-bit offset.
    assign off_ext   = PC_W'($signed(ir_reg[3:0]));
    assign pc_plus1  = pc_reg + PC_W'(1);
    assign pc_branch = pc_reg + off_ext;

    assign imem_addr = pc_reg;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_dump
            assign reg_dump[2*gi +: 2] = rf_reg[gi];
        end
    endgenerate

`ifdef NRISC_RETIRE_CNT_EN
    assign retired = retired_reg;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= S_IDLE;
            pc_reg      <= RESET_PC;
            ir_reg      <= 8'h00;
            rf_reg      <= '0;
            zflag_reg   <= 1'b0;
            res_reg     <= 2'b00;
            zero_reg    <= 1'b0;
            ALUctl      <= 4'hF;
            A           <= 2'b00;
            B           <= 2'b00;
            imem_req    <= 1'b0;
            halted      <= 1'b0;
`ifdef NRISC_RETIRE_CNT_EN
            retired_reg <= 16'h0000;
`endif
        end else begin
            case (state_reg)
                S_IDLE: begin
                    state_reg <= S_FETCH;
                    imem_req  <= 1'b1;
                end
                S_FETCH: begin
                    if (imem_valid) begin
                        ir_reg    <= imem_rdata;
                        imem_req  <= 1'b0;
                        state_reg <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    ALUctl    <= is_alu ? op : 4'hF;
                    A         <= rf_reg[rs];
                    B         <= rf_reg[rt];
                    state_reg <= S_EXEC;
                end
                S_EXEC: begin
                    res_reg   <= ALUOut[1:0];
                    zero_reg  <= Zero;
                    state_reg <= S_WB;
                end
                S_WB: begin
                    if (is_alu) begin
                        rf_reg[rs] <= res_reg;
                        zflag_reg  <= zero_reg;
                    end
                    case (op)
                        4'd8:    pc_reg <= zflag_reg ? pc_branch : pc_plus1;
                        4'd9:    pc_reg <= pc_branch;
                        4'd15:   pc_reg <= pc_reg;
                        default: pc_reg <= pc_plus1;
                    endcase
                    if (op == 4'd15) begin
                        halted    <= 1'b1;
                        state_reg <= S_HALT;
                    end else begin
                        imem_req  <= 1'b1;
                        state_reg <= S_FETCH;
                    end
`ifdef NRISC_RETIRE_CNT_EN
                    retired_reg <= retired_reg + 16'd1;
`endif
                end
                S_HALT: begin
                    state_reg <= S_HALT;
                end
                default: begin
                    state_reg <= S_IDLE;
                    imem_req  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nrisc_control.sv
// ---------------------------------------------------------------------------
// tb_nrisc_control
//
// Self-checking bench for nrisc_control. A small ALU is modelled
// combinationally. An instruction-level reference model predicts the
// following values every cycle: the fetch port, the registered ALU controls,
// the register file, halted, and (when NRISC_RETIRE_CNT_EN is defined)
// retired. Directed programs pin the model with literal values. Randomised
// programs, wait states and stray valid pulses exercise the rest.
// ---------------------------------------------------------------------------
module tb_nrisc_control;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic [7:0]  imem_rdata = 8'h00;
    logic        imem_valid = 1'b0;
    logic [3:0]  ALUctl;
    logic [1:0]  A;
    logic [1:0]  B;
    logic [8:0]  ALUOut;
    logic        Zero;
    logic        halted;
    logic [7:0]  reg_dump;
`ifdef NRISC_RETIRE_CNT_EN
    logic [15:0] retired;
`endif

    always #5 clk = ~clk;

    nrisc_control #(.PC_W(8), .RESET_PC(8'h00)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .imem_valid (imem_valid),
        .ALUctl     (ALUctl),
        .A          (A),
        .B          (B),
        .ALUOut     (ALUOut),
        .Zero       (Zero),
        .halted     (halted),
        .reg_dump   (reg_dump)
`ifdef NRISC_RETIRE_CNT_EN
        ,
        .retired    (retired)
`endif
    );

    // ALU arithmetic on 9 bits, shared by the bench ALU and the model.
    function automatic logic [8:0] alu_fn(input logic [3:0] ctl, input logic [1:0] a, input logic [1:0] b);
        case (ctl)
            4'd0:    return (a < b) ? 9'd1 : 9'd0;
            4'd2:    return {7'd0, b};
            4'd4:    return {7'd0, a} + 9'd1;
            4'd5:    return {7'd0, a} - {7'd0, b};
            4'd7:    return {7'd0, a} + {7'd0, b};
            default: return 9'd0;
        endcase
    endfunction

    always_comb begin
        ALUOut = alu_fn(ALUctl, A, B);
        Zero   = (ALUOut == 9'd0);
    end

    // ---------------- reference model ----------------
    logic [7:0]  mem [256];
    logic [1:0]  m_r [4];
    logic [7:0]  m_pc;
    logic        m_z;
    logic [3:0]  m_ctl;
    logic [1:0]  m_a, m_b;
    logic        m_halt;
    logic [15:0] m_ret;
    int          m_commits = 0;
    logic [7:0]  p_ir;
    logic [3:0]  p_ctl;
    logic [1:0]  p_a, p_b;
    int          bph = 0;      // 0 reset/idle, 1 fetching, 2 instruction in flight, 3 halted
    int          k = 0;        // clock edges since the fetch was accepted
    int          wait_left = 0;
    int          wait_mode = 0; // <0 random wait states, else fixed count
    bit          garbage_en = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 4; i++) m_r[i] = 2'b00;
        m_pc = 8'h00; m_z = 1'b0; m_ctl = 4'hF; m_a = 2'b00; m_b = 2'b00;
        m_halt = 1'b0; m_ret = 16'h0000; bph = 0; k = 0;
    endfunction

    function automatic bit is_alu_op(input logic [3:0] op);
        return (op == 4'd0) || (op == 4'd2) || (op == 4'd4) || (op == 4'd5) || (op == 4'd7);
    endfunction

    function automatic int next_wait();
        return (wait_mode < 0) ? int'($urandom_range(0, 3)) : wait_mode;
    endfunction

    function automatic void accept(input logic [7:0] ir);
        p_ir  = ir;
        p_ctl = is_alu_op(ir[7:4]) ? ir[7:4] : 4'hF;
        p_a   = m_r[ir[3:2]];
        p_b   = m_r[ir[1:0]];
    endfunction

    function automatic void commit();
        logic [3:0] op;
        logic [8:0] res;
        logic [7:0] off;
        op  = p_ir[7:4];
        off = {{4{p_ir[3]}}, p_ir[3:0]};
        if (is_alu_op(op)) begin
            res = alu_fn(op, p_a, p_b);
            m_r[p_ir[3:2]] = res[1:0];
            m_z = (res == 9'd0);
        end
        if (op == 4'd8)      m_pc = m_z ? m_pc + off : m_pc + 8'd1;
        else if (op == 4'd9) m_pc = m_pc + off;
        else if (op != 4'd15) m_pc = m_pc + 8'd1;
        m_ret = m_ret + 16'd1;
        m_commits++;
        if (op == 4'd15) begin
            m_halt = 1'b1; bph = 3;
        end else begin
            bph = 1; wait_left = next_wait();
        end
    endfunction

    function automatic void check_outputs();
        chk("imem_req", {31'd0, imem_req}, {31'd0, (bph == 1)});
        if (bph == 1) chk("imem_addr", {24'd0, imem_addr}, {24'd0, m_pc});
        chk("reg_dump", {24'd0, reg_dump}, {24'd0, m_r[3], m_r[2], m_r[1], m_r[0]});
        chk("ALUctl", {28'd0, ALUctl}, {28'd0, m_ctl});
        chk("A", {30'd0, A}, {30'd0, m_a});
        chk("B", {30'd0, B}, {30'd0, m_b});
        chk("halted", {31'd0, halted}, {31'd0, m_halt});
`ifdef NRISC_RETIRE_CNT_EN
        chk("retired", {16'd0, retired}, {16'd0, m_ret});
`endif
    endfunction

    // One clock cycle: reset control, compare, drive, then model update.
    task automatic step(input logic rst_val);
        @(negedge clk);
        if (!rst_val) begin
            rst_n = 1'b0;
            model_reset();
        end else begin
            rst_n = 1'b1;
        end
        #1;
        check_outputs();
        if (bph == 1) begin
            if (wait_left == 0) begin
                imem_valid = 1'b1; imem_rdata = mem[m_pc];
            end else begin
                imem_valid = 1'b0; imem_rdata = 8'($urandom); wait_left--;
            end
        end else begin
            imem_valid = garbage_en ? 1'($urandom_range(0, 1)) : 1'b0;
            imem_rdata = 8'($urandom);
        end
        @(posedge clk);
        if (rst_n) begin
            case (bph)
                0: begin bph = 1; wait_left = next_wait(); end
                1: if (imem_valid) begin accept(imem_rdata); bph = 2; k = 0; end
                2: begin
                    k++;
                    if (k == 1) begin m_ctl = p_ctl; m_a = p_a; m_b = p_b; end
                    else if (k == 3) commit();
                end
                default: ;
            endcase
        end
        #2;
    endtask

    task automatic run_instrs(input int n, output int steps);
        int target;
        target = m_commits + n;
        steps = 0;
        while (m_commits < target && steps < 300) begin
            step(1'b1);
            steps++;
        end
        chk("instr_timeout", m_commits, target);
    endtask

    task automatic load(input logic [7:0] p0, input logic [7:0] p1, input logic [7:0] p2, input int n);
        for (int i = 0; i < 256; i++) mem[i] = 8'h10;
        if (n > 0) mem[0] = p0;
        if (n > 1) mem[1] = p1;
        if (n > 2) mem[2] = p2;
        step(1'b0);
        step(1'b0);
    endtask

    int s1, s2;

    initial begin
        model_reset();
        wait_mode = 0;
        garbage_en = 1'b0;

        // INC r1, INC r1, ADD r1,r1 : 2+2=4 truncates to 0
        load(8'h44, 8'h44, 8'h75, 3);
        chk("reset_ctl", {28'd0, ALUctl}, 32'hF);
        chk("reset_req", {31'd0, imem_req}, 32'd0);
        run_instrs(2, s1);
        chk("t1_r1_is_2", {24'd0, reg_dump}, 32'h08);
        chk("t1_cycles_2instr", s1, 9);
        run_instrs(1, s2);
        chk("t1_add_trunc", {24'd0, reg_dump}, 32'h00);
        chk("t1_pc", {24'd0, imem_addr}, 32'h03);
        chk("t1_cycles_1instr", s2, 4);

        // SUB r0,r0 -> zflag=1, BEQZ +2 taken from PC 1 to 3
        load(8'h50, 8'h82, 8'h00, 2);
        run_instrs(2, s1);
        chk("t2_beqz_taken", {24'd0, imem_addr}, 32'h03);
        // INC r1 leaves zflag=0, BEQZ falls through to 2
        load(8'h44, 8'h82, 8'h00, 2);
        run_instrs(2, s1);
        chk("t2_beqz_fall", {24'd0, imem_addr}, 32'h02);

        // JMP -1 wraps to 0xFF, JMP +1 at 0xFF wraps to 0x00
        load(8'h9F, 8'h00, 8'h00, 1);
        mem[8'hFF] = 8'h91;
        run_instrs(1, s1);
        chk("t3_jmp_back", {24'd0, imem_addr}, 32'hFF);
        run_instrs(1, s1);
        chk("t3_jmp_wrap", {24'd0, imem_addr}, 32'h00);

        // Three wait states, stray valid pulses outside FETCH
        wait_mode = 3;
        garbage_en = 1'b1;
        load(8'h44, 8'h44, 8'h00, 2);
        run_instrs(1, s1);
        chk("t4_wait_cycles", s1, 8);
        chk("t4_r1", {24'd0, reg_dump}, 32'h04);
        wait_mode = 0;

        // Reset during EXEC of INC r1
        load(8'h44, 8'h44, 8'h00, 2);
        s1 = 0;
        while (!(bph == 2 && k == 1) && s1 < 50) begin step(1'b1); s1++; end
        chk("t5_reach_exec", {31'd0, (bph == 2 && k == 1)}, 32'd1);
        step(1'b0);
        chk("t5_r1_zero", {24'd0, reg_dump}, 32'h00);
        chk("t5_ctl_f", {28'd0, ALUctl}, 32'hF);
        chk("t5_pc_reset", {24'd0, imem_addr}, 32'h00);
        step(1'b0);
        run_instrs(1, s1);
        chk("t5_after_release", {24'd0, reg_dump}, 32'h04);
        chk("t5_cycles", s1, 5);
        garbage_en = 1'b0;

        // HALT
        load(8'hF0, 8'h00, 8'h00, 1);
        run_instrs(1, s1);
        for (int i = 0; i < 10; i++) step(1'b1);
        chk("t6_halted", {31'd0, halted}, 32'd1);
        chk("t6_req_low", {31'd0, imem_req}, 32'd0);
`ifdef NRISC_RETIRE_CNT_EN
        chk("t6_retired1", {16'd0, retired}, 32'd1);
`endif
        load(8'h44, 8'hF0, 8'h00, 2);
        run_instrs(2, s1);
        for (int i = 0; i < 6; i++) step(1'b1);
        chk("t6_r1_then_halt", {24'd0, reg_dump}, 32'h04);
`ifdef NRISC_RETIRE_CNT_EN
        chk("t6_retired2", {16'd0, retired}, 32'd2);
`endif

        // Randomised programs without HALT, random waits, stray valids, one reset
        wait_mode = -1;
        garbage_en = 1'b1;
        for (int blk = 0; blk < 4; blk++) begin
            for (int i = 0; i < 256; i++)
                mem[i] = {4'($urandom_range(0, 14)), 4'($urandom)};
            step(1'b0);
            step(1'b0);
            for (int c = 0; c < 600; c++)
                step((c == 300 + blk * 7) ? 1'b0 : 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
